// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS core: opcodes, function codes,
// ALU function encoding, controller states and the default reset PC.
package mips_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0040_0000;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  // ALU function: {sub, bool[1:0], shift, math}
  localparam logic [4:0] AluAdd  = 5'b00001;
  localparam logic [4:0] AluSub  = 5'b10001;
  localparam logic [4:0] AluSlt  = 5'b10011;
  localparam logic [4:0] AluSltu = 5'b10111;
  localparam logic [4:0] AluAnd  = 5'b00000;
  localparam logic [4:0] AluOr   = 5'b00100;
  localparam logic [4:0] AluXor  = 5'b01000;
  localparam logic [4:0] AluNor  = 5'b01100;
  localparam logic [4:0] AluSll  = 5'b00010;
  localparam logic [4:0] AluSrl  = 5'b01010;
  localparam logic [4:0] AluSra  = 5'b01110;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_e;

endpackage

// File: rtl/mips_regfile.sv
// Register file: two combinational reads, one synchronous write.
// Register 0 and any index at or above Nreg read as zero; writes there are dropped.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned Nreg  = 32,
  parameter int unsigned Dbits = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [4:0]       ra1_i,
  input  logic [4:0]       ra2_i,
  input  logic [4:0]       wa_i,
  input  logic [Dbits-1:0] wd_i,
  output logic [Dbits-1:0] rd1_o,
  output logic [Dbits-1:0] rd2_o
);

  logic [Dbits-1:0] regs_q [Nreg];

  // Synchronous clear on reset, otherwise write the addressed in-range register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < Nreg; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 1; i < Nreg; i++) begin
        if (wa_i == 5'(i)) regs_q[i] <= wd_i;
      end
    end
  end

  // Compare against each valid index so out-of-range reads fall through to zero
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    for (int i = 1; i < Nreg; i++) begin
      if (ra1_i == 5'(i)) rd1_o = regs_q[i];
      if (ra2_i == 5'(i)) rd2_o = regs_q[i];
    end
  end

endmodule

// File: rtl/mips_mc.sv
// Multicycle MIPS core: one controller FSM steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB sharing a single ALU; both memories use req/ready.
module mips_mc
  import mips_pkg::*;
#(
  parameter int unsigned Dbits    = 32,
  parameter int unsigned Nreg     = 32,
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [31:0]      pc,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      instr,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [Dbits-1:0] mem_writedata,
  input  logic             mem_ready,
  input  logic [Dbits-1:0] mem_readdata,
  output logic             retire,
  output logic             trap
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [Dbits-1:0] a_q, a_d;
  logic [Dbits-1:0] b_q, b_d;
  logic [Dbits-1:0] alu_q, alu_d;
  logic [Dbits-1:0] mdr_q, mdr_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];

  // Register file
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [Dbits-1:0] rf_wd, rf_rd1, rf_rd2;

  mips_regfile #(
    .Nreg  (Nreg),
    .Dbits (Dbits)
  ) u_regfile (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (rf_we),
    .ra1_i   (rs),
    .ra2_i   (rt),
    .wa_i    (rf_wa),
    .wd_i    (rf_wd),
    .rd1_o   (rf_rd1),
    .rd2_o   (rf_rd2)
  );

  // Immediate forms
  logic [Dbits-1:0] imm_sext, imm_zext, imm_lui;
  assign imm_sext = Dbits'($signed(imm));
  assign imm_zext = Dbits'(imm);
  assign imm_lui  = Dbits'({imm, 16'h0000});

  // Instruction decode
  logic [4:0]       alufn;
  logic [Dbits-1:0] imm_val;
  logic             b_imm, a_zero, wr_rt, illegal;
  logic             is_branch, is_bne, is_jump, is_jal, is_jr, is_lw, is_sw;

  // Decode the latched instruction into ALU controls and instruction class
  always_comb begin
    alufn     = AluAdd;
    imm_val   = imm_sext;
    b_imm     = 1'b0;
    a_zero    = 1'b0;
    wr_rt     = 1'b0;
    illegal   = 1'b0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    case (op)
      OpRtype: begin
        case (funct)
          FnAdd:   alufn = AluAdd;
          FnSub:   alufn = AluSub;
          FnAnd:   alufn = AluAnd;
          FnOr:    alufn = AluOr;
          FnXor:   alufn = AluXor;
          FnNor:   alufn = AluNor;
          FnSlt:   alufn = AluSlt;
          FnSltu:  alufn = AluSltu;
          FnSll:   alufn = AluSll;
          FnSrl:   alufn = AluSrl;
          FnSra:   alufn = AluSra;
          FnJr:    is_jr = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OpAddi:  begin alufn = AluAdd;  b_imm = 1'b1; wr_rt = 1'b1; end
      OpSlti:  begin alufn = AluSlt;  b_imm = 1'b1; wr_rt = 1'b1; end
      OpSltiu: begin alufn = AluSltu; b_imm = 1'b1; wr_rt = 1'b1; end
      OpAndi:  begin alufn = AluAnd;  b_imm = 1'b1; wr_rt = 1'b1; imm_val = imm_zext; end
      OpOri:   begin alufn = AluOr;   b_imm = 1'b1; wr_rt = 1'b1; imm_val = imm_zext; end
      OpXori:  begin alufn = AluXor;  b_imm = 1'b1; wr_rt = 1'b1; imm_val = imm_zext; end
      OpLui: begin
        // rs is ignored: the result is just the shifted immediate
        alufn   = AluAdd;
        b_imm   = 1'b1;
        a_zero  = 1'b1;
        wr_rt   = 1'b1;
        imm_val = imm_lui;
      end
      OpLw:    begin b_imm = 1'b1; wr_rt = 1'b1; is_lw = 1'b1; end
      OpSw:    begin b_imm = 1'b1; is_sw = 1'b1; end
      OpBeq:   is_branch = 1'b1;
      OpBne:   begin is_branch = 1'b1; is_bne = 1'b1; end
      OpJ:     is_jump = 1'b1;
      OpJal:   begin is_jump = 1'b1; is_jal = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  // Shared ALU
  logic [Dbits-1:0] alu_a, alu_b, alu_y;
  logic [6:0]       sh_amt;

  assign alu_a  = a_zero ? '0 : a_q;
  assign alu_b  = b_imm ? imm_val : b_q;
  assign sh_amt = 7'(32'(ir_q[10:6]) % Dbits);

  // ALU function select
  always_comb begin
    case (alufn)
      AluAdd:  alu_y = alu_a + alu_b;
      AluSub:  alu_y = alu_a - alu_b;
      AluSlt:  alu_y = Dbits'($signed(alu_a) < $signed(alu_b));
      AluSltu: alu_y = Dbits'(alu_a < alu_b);
      AluAnd:  alu_y = alu_a & alu_b;
      AluOr:   alu_y = alu_a | alu_b;
      AluXor:  alu_y = alu_a ^ alu_b;
      AluNor:  alu_y = ~(alu_a | alu_b);
      AluSll:  alu_y = alu_b << sh_amt;
      AluSrl:  alu_y = alu_b >> sh_amt;
      AluSra:  alu_y = Dbits'($signed(alu_b) >>> sh_amt);
      default: alu_y = '0;
    endcase
  end

  logic        br_taken;
  logic [31:0] jmp_target;

  assign br_taken   = (a_q == b_q) ^ is_bne;
  assign jmp_target = {pc_q[31:28], ir_q[25:0], 2'b00};

  // Controller next-state, datapath register loads and handshake outputs
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    tgt_d    = tgt_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wa    = '0;
    rf_wd    = '0;
    retire   = 1'b0;
    trap     = 1'b0;
    imem_req = 1'b0;
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = instr;
          pc_d    = pc_q + 32'd4;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rf_rd1;
        b_d     = rf_rd2;
        tgt_d   = pc_q + (32'($signed(imm)) << 2);
        state_d = EXEC;
      end
      EXEC: begin
        alu_d = alu_y;
        if (illegal) begin
          trap    = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_branch) begin
          retire  = 1'b1;
          if (br_taken) pc_d = tgt_q;
          state_d = FETCH;
        end else if (is_jump) begin
          retire  = 1'b1;
          pc_d    = jmp_target;
          rf_we   = is_jal;
          rf_wa   = 5'(Nreg - 1);
          rf_wd   = Dbits'(pc_q);
          state_d = FETCH;
        end else if (is_jr) begin
          retire  = 1'b1;
          pc_d    = 32'(a_q);
          state_d = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_wr  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_d   = mem_readdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = 1'b1;
        rf_wa   = wr_rt ? rt : rd;
        rf_wd   = is_lw ? mdr_q : alu_q;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // A frozen cycle completes nothing, so suppress its pulses and writes
    if (reset || !enable) begin
      retire = 1'b0;
      trap   = 1'b0;
      rf_we  = 1'b0;
    end
    if (reset) begin
      imem_req = 1'b0;
      mem_req  = 1'b0;
      mem_wr   = 1'b0;
    end
  end

  // State and datapath registers; reset wins over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      tgt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else if (enable) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tgt_q   <= tgt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  assign pc            = pc_q;
  assign mem_addr      = 32'(alu_q);
  assign mem_writedata = b_q;

endmodule

// File: tb/tb_mips_mc.sv
// Directed bench for mips_mc: a 32-bit core with a stallable data memory and
// a 16-bit / 8-register core, each running small hand-assembled programs.
module tb_mips_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit core
  logic        reset, enable, imem_req, imem_ready, mem_req, mem_wr, mem_ready;
  logic        retire, trap;
  logic [31:0] pc, instr, mem_addr, mem_writedata, mem_readdata;

  // 16-bit core
  logic        reset16, enable16, imem_req16, imem_ready16, mem_req16, mem_wr16, mem_ready16;
  logic        retire16, trap16;
  logic [31:0] pc16, instr16, mem_addr16;
  logic [15:0] mem_writedata16, mem_readdata16;

  logic [31:0] imem_a [64];
  logic [31:0] imem_c [64];
  logic [31:0] dmem [16];
  int          mem_delay;
  int          wait_cnt;
  int          n_chk = 0;
  int          n_err = 0;

  mips_mc dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .instr         (instr),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_ready     (mem_ready),
    .mem_readdata  (mem_readdata),
    .retire        (retire),
    .trap          (trap)
  );

  mips_mc #(
    .Dbits (16),
    .Nreg  (8)
  ) dut16 (
    .clk           (clk),
    .reset         (reset16),
    .enable        (enable16),
    .pc            (pc16),
    .imem_req      (imem_req16),
    .imem_ready    (imem_ready16),
    .instr         (instr16),
    .mem_req       (mem_req16),
    .mem_wr        (mem_wr16),
    .mem_addr      (mem_addr16),
    .mem_writedata (mem_writedata16),
    .mem_ready     (mem_ready16),
    .mem_readdata  (mem_readdata16),
    .retire        (retire16),
    .trap          (trap16)
  );

  // Memory models
  assign imem_ready     = 1'b1;
  assign instr          = imem_a[pc[7:2]];
  assign mem_ready      = mem_req && (wait_cnt >= mem_delay);
  assign mem_readdata   = dmem[mem_addr[5:2]];
  assign imem_ready16   = 1'b1;
  assign instr16        = imem_c[pc16[7:2]];
  assign mem_ready16    = mem_req16;
  assign mem_readdata16 = 16'h0000;

  always @(posedge clk) begin
    if (!mem_req || (mem_ready && enable)) wait_cnt <= 0;
    else if (enable) wait_cnt <= wait_cnt + 1;
    if (reset) begin
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
    end else if (enable && mem_req && mem_ready && mem_wr) begin
      dmem[mem_addr[5:2]] <= mem_writedata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from its FETCH cycle; checks latency, trap and held address
  task automatic do_instr(input bit sel, input string tag, input int exp_lat,
                          input logic [31:0] exp_addr, input bit exp_trap);
    int n;
    n = 1;
    while (!(sel ? retire16 : retire) && n < 40) begin
      if (sel ? mem_req16 : mem_req) check({tag, "_addr"}, sel ? mem_addr16 : mem_addr, exp_addr);
      step();
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_trap"}, sel ? trap16 : trap, exp_trap);
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    reset16   = 1'b1;
    enable16  = 1'b1;
    mem_delay = 0;
    for (int i = 0; i < 64; i++) begin
      imem_a[i] = 32'h0;
      imem_c[i] = 32'h0;
    end

    // Program A: ALU ops, stalled sw/lw, branch loop
    imem_a[0] = 32'h2001FFFB;  // addi $1,$0,-5
    imem_a[1] = 32'h0020102B;  // sltu $2,$1,$0
    imem_a[2] = 32'h0020202A;  // slt  $4,$1,$0
    imem_a[3] = 32'hAC010008;  // sw   $1,8($0)
    imem_a[4] = 32'h8C030008;  // lw   $3,8($0)
    imem_a[5] = 32'h00012843;  // sra  $5,$1,1
    imem_a[6] = 32'h00013702;  // srl  $6,$1,28
    imem_a[7] = 32'h3C071234;  // lui  $7,0x1234
    imem_a[8] = 32'h34E78001;  // ori  $7,$7,0x8001
    imem_a[9] = 32'h1000FFFF;  // beq  $0,$0,-1

    step();
    step();
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_retire", retire, 1'b0);
    check("rst_trap", trap, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_writedata, 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_imem_req", imem_req, 1'b1);

    do_instr(0, "addi", 4, 32'h0, 0);
    check("r1", dut.u_regfile.regs_q[1], 32'hFFFF_FFFB);
    do_instr(0, "sltu", 4, 32'h0, 0);
    check("r2", dut.u_regfile.regs_q[2], 32'h0);
    do_instr(0, "slt", 4, 32'h0, 0);
    check("r4", dut.u_regfile.regs_q[4], 32'h1);
    mem_delay = 3;
    do_instr(0, "sw", 7, 32'h8, 0);
    check("dmem2", dmem[2], 32'hFFFF_FFFB);
    do_instr(0, "lw", 8, 32'h8, 0);
    check("r3", dut.u_regfile.regs_q[3], 32'hFFFF_FFFB);
    mem_delay = 0;
    do_instr(0, "sra", 4, 32'h0, 0);
    check("r5", dut.u_regfile.regs_q[5], 32'hFFFF_FFFD);
    do_instr(0, "srl", 4, 32'h0, 0);
    check("r6", dut.u_regfile.regs_q[6], 32'h0000_000F);
    do_instr(0, "lui", 4, 32'h0, 0);
    check("r7_lui", dut.u_regfile.regs_q[7], 32'h1234_0000);
    do_instr(0, "ori", 4, 32'h0, 0);
    check("r7_ori", dut.u_regfile.regs_q[7], 32'h1234_8001);
    for (int k = 0; k < 2; k++) begin
      do_instr(0, "beq_loop", 3, 32'h0, 0);
      check("beq_pc", pc, 32'h0040_0024);
    end

    // Program B: j, jal, jr, then a store frozen by enable mid-access
    reset = 1'b1;
    for (int i = 0; i < 64; i++) imem_a[i] = 32'h0;
    imem_a[0] = 32'h08100004;  // j   0x00400010
    imem_a[4] = 32'h0C100008;  // jal 0x00400020
    imem_a[8] = 32'h03E00008;  // jr  $31
    imem_a[5] = 32'hAC1F0004;  // sw  $31,4($0)
    imem_a[6] = 32'h1000FFFF;  // beq $0,$0,-1
    step();
    step();
    check("rst2_r1", dut.u_regfile.regs_q[1], 32'h0);
    reset = 1'b0;
    #1;
    do_instr(0, "j", 3, 32'h0, 0);
    check("j_pc", pc, 32'h0040_0010);
    do_instr(0, "jal", 3, 32'h0, 0);
    check("jal_pc", pc, 32'h0040_0020);
    check("jal_link", dut.u_regfile.regs_q[31], 32'h0040_0014);
    do_instr(0, "jr", 3, 32'h0, 0);
    check("jr_pc", pc, 32'h0040_0014);
    step();
    step();
    step();
    check("frz_in_mem", mem_req, 1'b1);
    enable = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("frz_retire", retire, 1'b0);
      check("frz_mem_req", mem_req, 1'b1);
      check("frz_mem_wr", mem_wr, 1'b1);
      check("frz_mem_addr", mem_addr, 32'h4);
      check("frz_wdata", mem_writedata, 32'h0040_0014);
      check("frz_pc", pc, 32'h0040_0018);
      step();
    end
    check("frz_no_write", dmem[1], 32'h0);
    enable = 1'b1;
    #1;
    check("unfrz_retire", retire, 1'b1);
    step();
    check("unfrz_dmem1", dmem[1], 32'h0040_0014);
    check("unfrz_fetch", imem_req, 1'b1);
    check("unfrz_pc", pc, 32'h0040_0018);
    do_instr(0, "park", 3, 32'h0, 0);

    // Program C on the 16-bit core
    imem_c[0] = 32'h3C011234;  // lui  $1,0x1234
    imem_c[1] = 32'h20010003;  // addi $1,$0,3
    imem_c[2] = 32'h20090007;  // addi $9,$0,7 (out of range)
    imem_c[3] = 32'h01211025;  // or   $2,$9,$1
    imem_c[4] = 32'hFC000000;  // opcode 0x3F
    imem_c[5] = 32'h1000FFFF;  // beq  $0,$0,-1
    reset16 = 1'b0;
    #1;
    check("c_pc0", pc16, 32'h0040_0000);
    do_instr(1, "c_lui", 4, 32'h0, 0);
    check("c_r1_lui", dut16.u_regfile.regs_q[1], 16'h0000);
    do_instr(1, "c_addi", 4, 32'h0, 0);
    check("c_r1", dut16.u_regfile.regs_q[1], 16'h0003);
    do_instr(1, "c_addi9", 4, 32'h0, 0);
    check("c_r1_no_alias", dut16.u_regfile.regs_q[1], 16'h0003);
    do_instr(1, "c_or", 4, 32'h0, 0);
    check("c_r2", dut16.u_regfile.regs_q[2], 16'h0003);
    do_instr(1, "c_illegal", 3, 32'h0, 1);
    check("c_trap_pc", pc16, 32'h0040_0014);
    do_instr(1, "c_park", 3, 32'h0, 0);
    check("c_park_pc", pc16, 32'h0040_0014);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
